ahfp_f2f_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one fixed-to-float converter pipeline between `NUM_REQ` requesters. It accepts 32-bit two's-complement fixed-point words over per-requester valid/ready ports and drives the converter input. It tracks each in-flight word's requester ID through the converter latency. Results are returned through a small output FIFO with valid/ready backpressure; credit-based issue guarantees that no converter result is ever dropped.

---
 rtl/ahfp_f2f_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_ahfp_f2f_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahfp_f2f_arbiter.sv
// Round-robin arbiter feeding a shared fixed-to-float converter, with credit-based issue into a result FIFO.
// Optional macro AHFP_F2F_ZERO_FIX_EN forces results of zero input words to 32'h0.
module ahfp_f2f_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int CONV_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           conv_in,
  input  logic [31:0]           conv_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_data,
  output logic [ID_W-1:0]       res_id
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + CONV_LAT + 1) + 1;
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [31:0]          req_word [NUM_REQ];
  logic [ID_W-1:0]      last_ptr_reg, last_ptr_next;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      scan_cand;
  int                   scan_sum;
  logic                 grant_any;
  logic                 xfer;
  logic                 pop;
  logic                 issue_ok;
  logic [SUM_W-1:0]     inflight;
  logic [SUM_W-1:0]     credit_used;

  logic [CONV_LAT-1:0]  sh_valid_reg, sh_valid_next;
  logic [ID_W-1:0]      sh_id_reg  [CONV_LAT];
  logic [ID_W-1:0]      sh_id_next [CONV_LAT];
`ifdef AHFP_F2F_ZERO_FIX_EN
  logic [CONV_LAT-1:0]  sh_zero_reg, sh_zero_next;
`endif

  logic [31:0]          mem_data_reg [FIFO_DEPTH];
  logic [ID_W-1:0]      mem_id_reg   [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic                 fifo_wr;
  logic [31:0]          fifo_wr_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[32*gi +: 32];
    end
  endgenerate

  // Credits: every FIFO slot is either occupied or reserved by an in-flight word.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < CONV_LAT; k++) begin
      inflight = inflight + SUM_W'(sh_valid_reg[k]);
    end
  end

  assign res_valid   = (count_reg != '0);
  assign pop         = res_valid & res_ready;
  assign credit_used = SUM_W'(count_reg) + inflight - SUM_W'(pop);
  assign issue_ok    = (credit_used < SUM_W'(FIFO_DEPTH));

  // Rotating search starting just above the last granted requester.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = 0;
    scan_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_sum = int'(last_ptr_reg) + k;
      if (scan_sum >= NUM_REQ) begin
        scan_sum = scan_sum - NUM_REQ;
      end
      scan_cand = ID_W'(scan_sum);
      if (!grant_any && req_valid[scan_cand]) begin
        grant_any = 1'b1;
        grant_idx = scan_cand;
      end
    end
    if (!issue_ok || !rst_n) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    conv_in   = 32'h0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
      conv_in              = req_word[grant_idx];
    end
  end

  assign xfer = grant_any;

  always_comb begin
    last_ptr_next = last_ptr_reg;
    if (xfer) begin
      last_ptr_next = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_ptr_reg <= LAST_RST;
    end else begin
      last_ptr_reg <= last_ptr_next;
    end
  end

  // Shadow pipeline tracks which requester owns each word inside the converter.
  generate
    for (gi = 0; gi < CONV_LAT; gi++) begin : g_shadow
      if (gi == 0) begin : g_head
        assign sh_valid_next[gi] = xfer;
        assign sh_id_next[gi]    = grant_idx;
`ifdef AHFP_F2F_ZERO_FIX_EN
        assign sh_zero_next[gi]  = (conv_in == 32'h0);
`endif
      end else begin : g_tail
        assign sh_valid_next[gi] = sh_valid_reg[gi-1];
        assign sh_id_next[gi]    = sh_id_reg[gi-1];
`ifdef AHFP_F2F_ZERO_FIX_EN
        assign sh_zero_next[gi]  = sh_zero_reg[gi-1];
`endif
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_valid_reg <= '0;
`ifdef AHFP_F2F_ZERO_FIX_EN
      sh_zero_reg  <= '0;
`endif
      for (int k = 0; k < CONV_LAT; k++) begin
        sh_id_reg[k] <= '0;
      end
    end else begin
      sh_valid_reg <= sh_valid_next;
`ifdef AHFP_F2F_ZERO_FIX_EN
      sh_zero_reg  <= sh_zero_next;
`endif
      for (int k = 0; k < CONV_LAT; k++) begin
        sh_id_reg[k] <= sh_id_next[k];
      end
    end
  end

  assign fifo_wr = sh_valid_reg[CONV_LAT-1];

`ifdef AHFP_F2F_ZERO_FIX_EN
  // The converter normalises zero to a non-zero encoding; restore a true zero.
  assign fifo_wr_data = sh_zero_reg[CONV_LAT-1] ? 32'h0 : conv_out;
`else
  assign fifo_wr_data = conv_out;
`endif

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (fifo_wr) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
    if (fifo_wr && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!fifo_wr && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_data_reg[k] <= 32'h0;
        mem_id_reg[k]   <= '0;
      end
    end else if (fifo_wr) begin
      mem_data_reg[wr_ptr_reg] <= fifo_wr_data;
      mem_id_reg[wr_ptr_reg]   <= sh_id_reg[CONV_LAT-1];
    end
  end

  assign res_data = mem_data_reg[rd_ptr_reg];
  assign res_id   = mem_id_reg[rd_ptr_reg];

endmodule

// File: tb/tb_ahfp_f2f_arbiter.sv
// Scoreboard bench for ahfp_f2f_arbiter with a behavioural Q16.16-to-float converter model.
module tb_ahfp_f2f_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int ID_W       = 2;
  localparam int CONV_LAT   = 1;
  localparam int FIFO_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           conv_in;
  logic [31:0]           conv_out;
  logic                  res_valid;
  logic                  res_ready;
  logic [31:0]           res_data;
  logic [ID_W-1:0]       res_id;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } exp_t;

  exp_t               sb_q[$];
  int                 grant_log[$];
  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 n_xfer = 0;
  logic [NUM_REQ-1:0] last_xfer = '0;
  logic [31:0]        conv_pipe [CONV_LAT];

  ahfp_f2f_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CONV_LAT(CONV_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .conv_in(conv_in), .conv_out(conv_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  always #5 clk = ~clk;

  // Signed Q16.16 to single precision, truncating; zero normalises to 2^-16.
  function automatic logic [31:0] fx2fl(input logic [31:0] x);
    logic [31:0] mag;
    logic [31:0] m;
    logic [7:0]  e;
    int          p;
    mag = x[31] ? (~x + 32'd1) : x;
    p = 0;
    for (int b = 0; b < 32; b++) if (mag[b]) p = b;
    if (p >= 23) m = mag >> (p - 23);
    else         m = mag << (23 - p);
    e = 8'(p - 16 + 127);
    return {x[31], e, m[22:0]};
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] x);
`ifdef AHFP_F2F_ZERO_FIX_EN
    if (x == 32'h0) return 32'h0;
`endif
    return fx2fl(x);
  endfunction

  always @(posedge clk) begin
    conv_pipe[0] <= fx2fl(conv_in);
    for (int k = 1; k < CONV_LAT; k++) conv_pipe[k] <= conv_pipe[k-1];
  end
  assign conv_out = conv_pipe[CONV_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Monitor: handshakes are sampled mid-cycle, when inputs and state are settled.
  always @(negedge clk) begin
    exp_t e;
    last_xfer = '0;
    if (rst_n) begin
      check("grant_onehot", 32'($onehot0(req_ready)), 32'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          check("conv_in", conv_in, req_data[32*i +: 32]);
          e.id   = ID_W'(i);
          e.data = exp_data(req_data[32*i +: 32]);
          sb_q.push_back(e);
          grant_log.push_back(i);
          n_xfer++;
          last_xfer[i] = 1'b1;
        end
      end
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          $display("result id=%0d data=%h (expect id=%0d data=%h)", res_id, res_data, e.id, e.data);
          check("res_id", 32'(res_id), 32'(e.id));
          check("res_data", res_data, e.data);
        end
      end
    end
  end

  // New word for every requester whose previous word was just accepted.
  task automatic refresh_data();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_xfer[i]) req_data[32*i +: 32] = $urandom();
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0) break;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = $urandom();

    // Reset held with every requester valid.
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", res_data, 32'd0);
      check("rst_res_id", 32'(res_id), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    grant_log.delete();
    n_xfer = 0;
    @(negedge clk);
    check("first_grant", 32'(req_ready), 32'b0001);

    // Fairness: 16 transfers with everyone valid.
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      refresh_data();
      if (n_xfer >= 16) break;
    end
    req_valid = '0;
    check("fair_count", 32'(grant_log.size()), 32'd16);
    for (int k = 0; k < 16 && k < grant_log.size(); k++) begin
      check("fair_order", 32'(grant_log[k]), 32'(k % NUM_REQ));
    end
    wait_drain();

    // Latency from a single transfer to res_valid.
    @(posedge clk); #1;
    req_data[95:64] = 32'h00010000;
    req_valid = 4'b0100;
    @(negedge clk);
    check("lat_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lat++;
      if (res_valid) break;
    end
    check("latency", 32'(lat), 32'(CONV_LAT + 1));
    check("lat_res_id", 32'(res_id), 32'd2);
    check("lat_res_data", res_data, 32'h3F800000);
    wait_drain();

    // Backpressure: result FIFO full, issue must stall at exactly FIFO_DEPTH.
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = '1;
    n_xfer = 0;
    repeat (10) begin
      @(posedge clk); #1;
      refresh_data();
    end
    @(negedge clk);
    check("bp_xfers", 32'(n_xfer), 32'(FIFO_DEPTH));
    check("bp_stall", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      refresh_data();
    end
    req_valid = '0;
    wait_drain();

    // Zero input word from requester 1.
    @(posedge clk); #1;
    req_data[63:32] = 32'h0;
    req_valid = 4'b0010;
    @(negedge clk);
    check("zero_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (res_valid) break;
    end
`ifdef AHFP_F2F_ZERO_FIX_EN
    check("zero_data", res_data, 32'h00000000);
`else
    check("zero_data", res_data, 32'h37800000);
`endif
    wait_drain();

    // Reset with two words in flight: nothing may emerge afterwards.
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = 4'b0011;
    @(posedge clk); #1;
    refresh_data();
    @(posedge clk); #1;
    check("mid_xfers_queued", 32'(sb_q.size()), 32'd2);
    req_valid = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    res_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_res_valid", 32'(res_valid), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    check("post_rst_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
